bchecc_seq: RTL and testbench

BCHECC_SEQ -- requirements
Module: bchecc_seq

---
 rtl/bchecc_seq_pkg.sv | 28 ++
 rtl/bchecc_seq_if.sv | 34 +++
 rtl/bchecc_seq.sv | 179 +++++++++++++++++
 tb/tb_bchecc_seq.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bchecc_seq_pkg.sv
// Shared types and constants for the BCH ECC engine job sequencer:
// FSM state encoding, SFR map, access sizes and ECC_STAT bit positions.
package bchecc_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WCFG,
      WCTRL,
      WAIT,
      POLL,
      CLRF,
      DONE
   } state_t;

   localparam logic [3:0] ADDR_CTRL = 4'h0;
   localparam logic [3:0] ADDR_CFG  = 4'h4;
   localparam logic [3:0] ADDR_STAT = 4'h8;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int BUSY  = 0;
   localparam int ERR   = 1;
   localparam int FAIL  = 2;
   localparam int BLOCK = 3;

endpackage

// File: rtl/bchecc_seq_if.sv
// Job handshake and SFR bus of the BCH ECC sequencer.
// master = sequencer side, slave = job requester plus SFR responder.
interface bchecc_seq_if;

   logic        job_start_i;
   logic [3:0]  job_ctrl_i;
   logic [9:0]  job_cfg_i;
   logic        clr_fail_i;
   logic        job_ready_o;
   logic        job_done_o;
   logic [7:0]  job_stat_o;
   logic        job_timeout_o;

   logic        sfr_en_o;
   logic        sfr_rd_o;
   logic        sfr_wr_o;
   logic [1:0]  sfr_size_o;
   logic [3:0]  sfr_addr_o;
   logic [31:0] sfr_wdata_o;
   logic [31:0] sfr_rdata_i;

   modport master (
      input  job_start_i, job_ctrl_i, job_cfg_i, clr_fail_i, sfr_rdata_i,
      output job_ready_o, job_done_o, job_stat_o, job_timeout_o,
      output sfr_en_o, sfr_rd_o, sfr_wr_o, sfr_size_o, sfr_addr_o, sfr_wdata_o
   );

   modport slave (
      output job_start_i, job_ctrl_i, job_cfg_i, clr_fail_i, sfr_rdata_i,
      input  job_ready_o, job_done_o, job_stat_o, job_timeout_o,
      input  sfr_en_o, sfr_rd_o, sfr_wr_o, sfr_size_o, sfr_addr_o, sfr_wdata_o
   );

endinterface

// File: rtl/bchecc_seq.sv
// BCH ECC job sequencer: writes ECC_CFG/ECC_CTRL, waits, polls ECC_STAT until not busy.
// Define BCHECC_SEQ_TIMEOUT_EN to bound polling at POLL_LIMIT reads.
//
// state | meaning
// IDLE  | ready for a job or a fail-clear request
// WCFG  | write job cfg to ECC_CFG (half-word)
// WCTRL | write job ctrl to ECC_CTRL (byte), load start wait
// WAIT  | START_WAIT idle cycles before the first poll
// POLL  | read ECC_STAT every cycle until busy clears (or limit)
// CLRF  | byte write of zero to ECC_STAT clearing the sticky fail
// DONE  | one-cycle job_done pulse
module bchecc_seq
   import bchecc_seq_pkg::*;
#(
   parameter int START_WAIT = 2,
   parameter int POLL_LIMIT = 1024
) (
   input logic          clk,
   input logic          rst,
   bchecc_seq_if.master bus
);

   if (START_WAIT < 1 || START_WAIT > 15) begin : g_bad_start_wait
      $error("bchecc_seq: START_WAIT must be 1..15");
   end
   if (POLL_LIMIT < 1 || POLL_LIMIT > 65535) begin : g_bad_poll_limit
      $error("bchecc_seq: POLL_LIMIT must be 1..65535");
   end

   localparam logic [15:0] WAIT_LOAD = 16'(START_WAIT);

   state_t      state, state_nxt;
   logic [15:0] cnt, cnt_nxt;
   logic [3:0]  ctrl_q;
   logic [9:0]  cfg_q;
   logic [7:0]  stat_q, stat_nxt;
   logic        timeout_nxt;
   logic        accept;
   logic        busy;
   logic [15:0] poll_load;
   logic        poll_limit_hit;

   logic        sfr_en, sfr_rd, sfr_wr;
   logic [1:0]  sfr_size;
   logic [3:0]  sfr_addr;
   logic [31:0] sfr_wdata;

   assign accept = (state == IDLE) && bus.job_start_i && !bus.clr_fail_i;
   assign busy   = bus.sfr_rdata_i[BUSY];

`ifdef BCHECC_SEQ_TIMEOUT_EN
   logic timeout_q;
   assign poll_load      = 16'(POLL_LIMIT);
   assign poll_limit_hit = (cnt == 16'd1);
`else
   assign poll_load      = '0;
   assign poll_limit_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         ctrl_q <= '0;
         cfg_q  <= '0;
         stat_q <= '0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         stat_q <= stat_nxt;
         if (accept) begin
            ctrl_q <= bus.job_ctrl_i;
            cfg_q  <= bus.job_cfg_i;
         end
      end
   end

`ifdef BCHECC_SEQ_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) timeout_q <= 1'b0;
      else     timeout_q <= timeout_nxt;
   end
   assign bus.job_timeout_o = timeout_q;
`else
   assign bus.job_timeout_o = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stat_nxt  = stat_q;
`ifdef BCHECC_SEQ_TIMEOUT_EN
      timeout_nxt = timeout_q;
`else
      timeout_nxt = 1'b0;
`endif
      case (state)
         IDLE: begin
            // a fail-clear request wins over a simultaneous start
            if (bus.clr_fail_i)       state_nxt = CLRF;
            else if (bus.job_start_i) state_nxt = WCFG;
         end
         WCFG:  state_nxt = WCTRL;
         WCTRL: begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_LOAD;
         end
         WAIT: begin
            if (cnt <= 16'd1) begin
               state_nxt = POLL;
               cnt_nxt   = poll_load;
            end else begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         POLL: begin
            if (!busy || poll_limit_hit) begin
               state_nxt   = DONE;
               stat_nxt    = bus.sfr_rdata_i[7:0];
               timeout_nxt = busy;
               cnt_nxt     = '0;
            end else if (cnt != 16'd0) begin
               cnt_nxt = cnt - 16'd1;
            end
         end
         CLRF:    state_nxt = IDLE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // SFR strobes depend only on registered state and captured job fields
   always_comb begin
      sfr_en    = 1'b0;
      sfr_rd    = 1'b0;
      sfr_wr    = 1'b0;
      sfr_size  = SZ_BYTE;
      sfr_addr  = ADDR_CTRL;
      sfr_wdata = '0;
      case (state)
         WCFG: begin
            sfr_en    = 1'b1;
            sfr_wr    = 1'b1;
            sfr_size  = SZ_HALF;
            sfr_addr  = ADDR_CFG;
            sfr_wdata = {22'b0, cfg_q};
         end
         WCTRL: begin
            sfr_en    = 1'b1;
            sfr_wr    = 1'b1;
            sfr_addr  = ADDR_CTRL;
            sfr_wdata = {28'b0, ctrl_q};
         end
         POLL: begin
            sfr_en   = 1'b1;
            sfr_rd   = 1'b1;
            sfr_addr = ADDR_STAT;
         end
         CLRF: begin
            sfr_en   = 1'b1;
            sfr_wr   = 1'b1;
            sfr_addr = ADDR_STAT;
         end
         default: ;
      endcase
   end

   assign bus.sfr_en_o    = sfr_en;
   assign bus.sfr_rd_o    = sfr_rd;
   assign bus.sfr_wr_o    = sfr_wr;
   assign bus.sfr_size_o  = sfr_size;
   assign bus.sfr_addr_o  = sfr_addr;
   assign bus.sfr_wdata_o = sfr_wdata;

   assign bus.job_ready_o = (state == IDLE);
   assign bus.job_done_o  = (state == DONE);
   assign bus.job_stat_o  = stat_q;

endmodule

// File: tb/tb_bchecc_seq.sv
// Self-checking bench for bchecc_seq: table of jobs against an ECC register responder,
// scoreboard queues for SFR accesses and job results, plus reset/clear corner sequences.
module tb_bchecc_seq;
   import bchecc_seq_pkg::*;

   localparam int SW = 2;
   localparam int PL = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   bchecc_seq_if bus();

   bchecc_seq #(.START_WAIT(SW), .POLL_LIMIT(PL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic        rd;
      logic [1:0]  size;
      logic [3:0]  addr;
      logic [31:0] wdata;
      int          ofs;
   } acc_t;

   typedef struct {
      logic [7:0] stat;
      logic       timeout;
      int         ofs;
   } res_t;

   typedef struct {
      logic [3:0] ctrl;
      logic [9:0] cfg;
      int         busy_polls;
      logic [7:0] stat_done;
      logic [7:0] exp_stat;
      logic       exp_to;
   } vec_t;

   acc_t exp_acc[$];
   res_t exp_res[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cyc = 0;

   int          rsp_busy_left = 0;
   logic [7:0]  rsp_stat = 8'h00;
   int          rsp_job_busy = 0;
   logic [7:0]  rsp_job_stat = 8'h00;
   logic [31:0] last_rdata = 32'h0;

   always @(posedge clk) cyc <= cyc + 1;

   // ECC register responder; bit2 (fail) is sticky until ECC_STAT is written
   always @(posedge clk) begin
      if (bus.sfr_en_o && bus.sfr_wr_o && bus.sfr_addr_o == ADDR_CTRL) begin
         rsp_busy_left <= rsp_job_busy;
         rsp_stat      <= (rsp_stat & 8'h04) | rsp_job_stat;
      end else if (bus.sfr_en_o && bus.sfr_wr_o && bus.sfr_addr_o == ADDR_STAT) begin
         rsp_stat <= bus.sfr_wdata_o[7:0];
      end else if (bus.sfr_en_o && bus.sfr_rd_o && rsp_busy_left != 0) begin
         rsp_busy_left <= rsp_busy_left - 1;
      end
   end
   assign bus.sfr_rdata_i = {24'h0, rsp_stat[7:1], (rsp_busy_left != 0)};

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic acc_t mk_acc(input logic wr, input logic rd, input logic [1:0] size,
                                   input logic [3:0] addr, input logic [31:0] wdata, input int ofs);
      acc_t a;
      a.wr = wr; a.rd = rd; a.size = size; a.addr = addr; a.wdata = wdata; a.ofs = ofs;
      return a;
   endfunction

   acc_t m_acc;
   res_t m_res;
   always @(negedge clk) begin
      if (bus.sfr_rd_o === 1'b1) last_rdata = bus.sfr_rdata_i;
      if (bus.sfr_en_o === 1'b1) begin
         if (exp_acc.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sfr_access unexpected wr=%b rd=%b addr=%h wdata=%h at cycle %0d, required none",
                     bus.sfr_wr_o, bus.sfr_rd_o, bus.sfr_addr_o, bus.sfr_wdata_o, cyc);
         end else begin
            m_acc = exp_acc.pop_front();
            check("sfr_access",
                  64'({bus.sfr_wr_o, bus.sfr_rd_o, bus.sfr_size_o, bus.sfr_addr_o, bus.sfr_wdata_o}),
                  64'({m_acc.wr, m_acc.rd, m_acc.size, m_acc.addr, m_acc.wdata}));
            check("sfr_access_cycle", 64'(cyc - acc_cyc), 64'(m_acc.ofs));
         end
      end else begin
         check("sfr_idle",
               64'({bus.sfr_wr_o, bus.sfr_rd_o, bus.sfr_size_o, bus.sfr_addr_o, bus.sfr_wdata_o}), 64'h0);
      end
      if (bus.job_done_o === 1'b1) begin
         if (exp_res.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL job_done unexpected pulse at cycle %0d, required no pulse", cyc);
         end else begin
            m_res = exp_res.pop_front();
            check("job_result", 64'({bus.job_stat_o, bus.job_timeout_o}), 64'({m_res.stat, m_res.timeout}));
            check("job_latency", 64'(cyc - acc_cyc), 64'(m_res.ofs));
            check("ready_in_done", 64'(bus.job_ready_o), 64'h0);
            if (bus.job_stat_o !== last_rdata[7:0])
               $display("note: last read word %h", last_rdata);
         end
      end
   end

   task automatic drive(input logic start, input logic clr, input logic [3:0] ctrl, input logic [9:0] cfg);
      bus.job_start_i = start;
      bus.clr_fail_i  = clr;
      bus.job_ctrl_i  = ctrl;
      bus.job_cfg_i   = cfg;
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      bus.job_start_i = 1'b0;
      bus.clr_fail_i  = 1'b0;
   endtask

   task automatic drain(input int budget);
      int k;
      k = 0;
      while ((exp_acc.size() != 0 || exp_res.size() != 0) && k < budget) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (exp_acc.size() != 0 || exp_res.size() != 0) begin
         errors++;
         $display("FAIL drain pending acc=%0d res=%0d after %0d cycles, required 0 0",
                  exp_acc.size(), exp_res.size(), budget);
         exp_acc.delete();
         exp_res.delete();
      end
      @(negedge clk);
   endtask

   task automatic push_job_accesses(input vec_t v, input int n);
      exp_acc.push_back(mk_acc(1'b1, 1'b0, SZ_HALF, ADDR_CFG, {22'b0, v.cfg}, 0));
      exp_acc.push_back(mk_acc(1'b1, 1'b0, SZ_BYTE, ADDR_CTRL, {28'b0, v.ctrl}, 1));
      for (int i = 0; i < n; i++)
         exp_acc.push_back(mk_acc(1'b0, 1'b1, SZ_BYTE, ADDR_STAT, 32'h0, 2 + SW + i));
   endtask

   task automatic run_job(input vec_t v);
      int   n;
      res_t r;
      n = v.busy_polls + 1;
`ifdef BCHECC_SEQ_TIMEOUT_EN
      if (n > PL) n = PL;
`endif
      rsp_job_busy = v.busy_polls;
      rsp_job_stat = v.stat_done;
      push_job_accesses(v, n);
      r.stat = v.exp_stat; r.timeout = v.exp_to; r.ofs = 2 + SW + n;
      exp_res.push_back(r);
      drive(1'b1, 1'b0, v.ctrl, v.cfg);
      drain(300);
   endtask

   initial begin
      vec_t tbl[10];
      vec_t rv;
      tbl[0] = '{4'h5, 10'h2A3, 3, 8'h00, 8'h00, 1'b0};
      tbl[1] = '{4'hA, 10'h3FF, 0, 8'h02, 8'h02, 1'b0};
      tbl[2] = '{4'h0, 10'h000, 1, 8'h08, 8'h08, 1'b0};
      tbl[3] = '{4'hF, 10'h155, 2, 8'h34, 8'h34, 1'b0};
      tbl[4] = '{4'h3, 10'h011, 0, 8'h00, 8'h00, 1'b0};
      tbl[5] = '{4'h6, 10'h200, 1, 8'h04, 8'h04, 1'b0};
      tbl[6] = '{4'h9, 10'h0AA, 0, 8'h00, 8'h00, 1'b0};
`ifdef BCHECC_SEQ_TIMEOUT_EN
      tbl[7] = '{4'hC, 10'h0F0, 1000, 8'h10, 8'h11, 1'b1};
`else
      tbl[7] = '{4'hC, 10'h0F0, 6, 8'h08, 8'h08, 1'b0};
`endif
      tbl[8] = '{4'h1, 10'h001, 0, 8'h02, 8'h02, 1'b0};
      tbl[9] = '{4'h5, 10'h2A3, 2, 8'h08, 8'h08, 1'b0};

      bus.job_start_i = 1'b0;
      bus.clr_fail_i  = 1'b0;
      bus.job_ctrl_i  = 4'h0;
      bus.job_cfg_i   = 10'h0;

      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_ready", 64'(bus.job_ready_o), 64'h1);
      check("reset_done", 64'(bus.job_done_o), 64'h0);
      check("reset_stat", 64'(bus.job_stat_o), 64'h0);
      check("reset_timeout", 64'(bus.job_timeout_o), 64'h0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_ready", 64'(bus.job_ready_o), 64'h1);

      for (int i = 0; i < 4; i++) run_job(tbl[i]);

      // clear the sticky fail left by the last table job
      exp_acc.push_back(mk_acc(1'b1, 1'b0, SZ_BYTE, ADDR_STAT, 32'h0, 0));
      drive(1'b0, 1'b1, 4'h0, 10'h0);
      drain(20);
      repeat (3) @(negedge clk);
      check("stat_held_after_clr", 64'(bus.job_stat_o), 64'h34);
      run_job(tbl[4]);

      // start and clear together: only the clear runs
      run_job(tbl[5]);
      exp_acc.push_back(mk_acc(1'b1, 1'b0, SZ_BYTE, ADDR_STAT, 32'h0, 0));
      drive(1'b1, 1'b1, 4'h9, 10'h1FF);
      drain(20);
      repeat (4) @(negedge clk);
      check("stat_held_both", 64'(bus.job_stat_o), 64'h04);
      check("ready_after_both", 64'(bus.job_ready_o), 64'h1);
      run_job(tbl[6]);

      run_job(tbl[7]);
      repeat (3) @(negedge clk);
      check("timeout_held", 64'(bus.job_timeout_o), 64'(tbl[7].exp_to));
      run_job(tbl[8]);

      // reset during the second poll read
      rv = '{4'h7, 10'h155, 5, 8'h00, 8'h00, 1'b0};
      rsp_job_busy = rv.busy_polls;
      rsp_job_stat = rv.stat_done;
      push_job_accesses(rv, 2);
      drive(1'b1, 1'b0, rv.ctrl, rv.cfg);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_sfr_en", 64'(bus.sfr_en_o), 64'h0);
      check("rst_ready", 64'(bus.job_ready_o), 64'h1);
      check("rst_done", 64'(bus.job_done_o), 64'h0);
      check("rst_stat", 64'(bus.job_stat_o), 64'h0);
      check("rst_timeout", 64'(bus.job_timeout_o), 64'h0);
      rst = 1'b0;
      drain(10);
      repeat (6) @(negedge clk);
      run_job(tbl[9]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d, required bench completion", cyc);
      $fatal(1, "watchdog");
   end

endmodule
